// File: rtl/ws2812_tx.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_tx
// Description : Serialises one 24-bit GRB pixel onto a WS2812 data line using
//               fixed-length bit slots with 0/1 high-time encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_tx #(
    parameter int CYCLES_PER_BIT = 15,
    parameter int T0H            = 4,
    parameter int T1H            = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_sreg,
    input  logic       transmit_pixel,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       data_out,
    output logic       busy,
    output logic       pixel_done,
    output logic       abort
);

    // Parameters are expected to satisfy 0 < T0H < T1H < CYCLES_PER_BIT.
    localparam int SLOT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

    localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(CYCLES_PER_BIT - 1);
    localparam logic [SLOT_W-1:0] c_t0h       = SLOT_W'(T0H);
    localparam logic [SLOT_W-1:0] c_t1h       = SLOT_W'(T1H);
    localparam logic [SLOT_W-1:0] c_slot_one  = SLOT_W'(1);
    localparam logic [4:0]        c_last_bit  = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state,      w_state_next;
    logic [23:0]       r_sreg,       w_sreg_next;
    logic              r_loaded,     w_loaded_next;
    logic [4:0]        r_bit_cnt,    w_bit_next;
    logic [SLOT_W-1:0] r_slot_cnt,   w_slot_next;
    logic              r_data_out,   w_data_next;
    logic              r_pixel_done, w_done_next;
    logic              r_abort,      w_abort_next;
    logic [23:0]       w_sreg_shift;
    logic [SLOT_W-1:0] w_th_cur;

    assign w_sreg_shift = {r_sreg[22:0], 1'b0};
    assign w_th_cur     = r_sreg[23] ? c_t1h : c_t0h;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sreg       <= '0;
            r_loaded     <= 1'b0;
            r_bit_cnt    <= '0;
            r_slot_cnt   <= '0;
            r_data_out   <= 1'b0;
            r_pixel_done <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sreg       <= w_sreg_next;
            r_loaded     <= w_loaded_next;
            r_bit_cnt    <= w_bit_next;
            r_slot_cnt   <= w_slot_next;
            r_data_out   <= w_data_next;
            r_pixel_done <= w_done_next;
            r_abort      <= w_abort_next;
        end
    end

    // data_out is computed from the next slot/sreg values so the line is
    // high from the very first cycle after the SEND-entry edge.
    always_comb begin
        w_state_next  = r_state;
        w_sreg_next   = r_sreg;
        w_loaded_next = r_loaded;
        w_bit_next    = r_bit_cnt;
        w_slot_next   = r_slot_cnt;
        w_data_next   = 1'b0;
        w_done_next   = 1'b0;
        w_abort_next  = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (load_sreg) begin
                    w_sreg_next   = {green, red, blue};
                    w_loaded_next = 1'b1;
                end
                if (r_state == ST_IDLE) begin
                    if (transmit_pixel && r_loaded) begin
                        w_state_next = ST_SEND;
                        w_bit_next   = '0;
                        w_slot_next  = '0;
                        w_data_next  = (w_sreg_next[23] ? c_t1h : c_t0h) != '0;
                    end
                end else if (!transmit_pixel) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_SEND: begin
                if (!transmit_pixel) begin
                    w_state_next  = ST_IDLE;
                    w_loaded_next = 1'b0;
                    w_abort_next  = 1'b1;
                    w_bit_next    = '0;
                    w_slot_next   = '0;
                end else if (r_slot_cnt == c_last_slot) begin
                    w_slot_next = '0;
                    w_sreg_next = w_sreg_shift;
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_next  = ST_DONE;
                        w_loaded_next = 1'b0;
                        w_done_next   = 1'b1;
                        w_bit_next    = '0;
                    end else begin
                        w_bit_next  = r_bit_cnt + 5'd1;
                        w_data_next = (w_sreg_shift[23] ? c_t1h : c_t0h) != '0;
                    end
                end else begin
                    w_slot_next = r_slot_cnt + c_slot_one;
                    w_data_next = w_slot_next < w_th_cur;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign data_out   = r_data_out;
    assign busy       = (r_state == ST_SEND);
    assign pixel_done = r_pixel_done;
    assign abort      = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_tx
// Description : Directed, table-driven self-checking bench for ws2812_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_tx;

    localparam int CPB    = 15;
    localparam int T0H_TB = 4;
    localparam int T1H_TB = 9;

    // mode: 0 full pixel, 1 drop transmit, 2 reset mid-send, 3 reload mid-send
    typedef struct {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        int         mode;
        int         stop_at;
        int         exp_highs;
        int         exp_dones;
        int         exp_aborts;
        int         exp_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_sreg = 1'b0;
    logic       transmit_pixel = 1'b0;
    logic [7:0] red = 8'h00;
    logic [7:0] green = 8'h00;
    logic [7:0] blue = 8'h00;
    logic       data_out;
    logic       busy;
    logic       pixel_done;
    logic       abort;

    int n_checks = 0;
    int n_errors = 0;

    ws2812_tx #(
        .CYCLES_PER_BIT(CPB),
        .T0H           (T0H_TB),
        .T1H           (T1H_TB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_sreg     (load_sreg),
        .transmit_pixel(transmit_pixel),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .data_out      (data_out),
        .busy          (busy),
        .pixel_done    (pixel_done),
        .abort         (abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits for the SEND-entry edge, then samples 362 cycles against the
    // slot-encoding model, applying the mode's mid-send disturbance.
    task automatic watch_pixel(input logic [23:0] pix, input int mode, input int stop_at,
                               output int wave_err, output int highs, output int dones,
                               output int aborts, output int busy_cnt);
        logic active, bv, exp_data, exp_done, exp_abort;
        int   bi, si;
        wave_err = 0;
        highs    = 0;
        dones    = 0;
        aborts   = 0;
        busy_cnt = 0;
        @(posedge clk);
        for (int k = 0; k < 362; k++) begin
            @(negedge clk);
            active    = (k < 24 * CPB) && !((mode == 1 || mode == 2) && k >= stop_at);
            bi        = k / CPB;
            si        = k % CPB;
            bv        = (bi < 24) ? pix[23 - bi] : 1'b0;
            exp_data  = active && (si < (bv ? T1H_TB : T0H_TB));
            exp_done  = (mode == 0 || mode == 3) && (k == 24 * CPB);
            exp_abort = (mode == 1) && (k == stop_at);
            if (data_out !== exp_data || busy !== active ||
                pixel_done !== exp_done || abort !== exp_abort) begin
                wave_err++;
            end
            highs    += int'(data_out);
            dones    += int'(pixel_done);
            aborts   += int'(abort);
            busy_cnt += int'(busy);
            if (mode == 1 && k == stop_at - 1) transmit_pixel = 1'b0;
            if (mode == 2 && k == stop_at - 1) rst = 1'b1;
            if (mode == 2 && k == stop_at)     rst = 1'b0;
            if (mode == 3 && k == 49) begin
                green     = 8'h00;
                red       = 8'h00;
                blue      = 8'h00;
                load_sreg = 1'b1;
            end
            if (mode == 3 && k == 50) load_sreg = 1'b0;
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   wave_err, highs, dones, aborts, busy_cnt, quiet;

        // highs = 9 per one-bit + 4 per zero-bit over the observed slots
        vecs[0] = '{8'hFF, 8'h00, 8'hAA, 0,   0, 156, 1, 0, 360};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 0,   0,  96, 1, 0, 360};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 0,   0, 216, 1, 0, 360};
        vecs[3] = '{8'h80, 8'h01, 8'h55, 0,   0, 126, 1, 0, 360};
        vecs[4] = '{8'hFF, 8'h00, 8'hAA, 1, 100,  63, 0, 1, 100};
        vecs[5] = '{8'h12, 8'h34, 8'h56, 2, 200,  77, 0, 0, 200};
        vecs[6] = '{8'hAB, 8'hCD, 8'hEF, 3,   0, 181, 1, 0, 360};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data_out", int'(data_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pixel_done", int'(pixel_done), 0);
        check("reset_abort", int'(abort), 0);
        rst = 1'b0;

        // Transmit without any load
        quiet = 0;
        transmit_pixel = 1'b1;
        repeat (40) begin
            @(negedge clk);
            quiet += int'(data_out | busy | pixel_done | abort);
        end
        check("noload_activity", quiet, 0);
        transmit_pixel = 1'b0;

        for (int i = 0; i < 7; i++) begin
            quiet = 0;
            repeat (2) begin
                @(negedge clk);
                quiet += int'(data_out | busy | pixel_done | abort);
            end
            @(posedge clk) #1;
            green     = vecs[i].g;
            red       = vecs[i].r;
            blue      = vecs[i].b;
            load_sreg = 1'b1;
            @(negedge clk);
            quiet += int'(data_out | busy | pixel_done | abort);
            @(posedge clk) #1;
            load_sreg      = 1'b0;
            transmit_pixel = 1'b1;
            check($sformatf("gap_quiet[%0d]", i), quiet, 0);
            watch_pixel({vecs[i].g, vecs[i].r, vecs[i].b}, vecs[i].mode, vecs[i].stop_at,
                        wave_err, highs, dones, aborts, busy_cnt);
            transmit_pixel = 1'b0;
            check($sformatf("wave[%0d]", i), wave_err, 0);
            check($sformatf("highs[%0d]", i), highs, vecs[i].exp_highs);
            check($sformatf("pixel_done[%0d]", i), dones, vecs[i].exp_dones);
            check($sformatf("abort[%0d]", i), aborts, vecs[i].exp_aborts);
            check($sformatf("busy_cycles[%0d]", i), busy_cnt, vecs[i].exp_busy);
        end

        // Load and transmit raised together from IDLE with nothing loaded
        repeat (2) @(negedge clk);
        @(posedge clk) #1;
        green          = 8'h0F;
        red            = 8'hF0;
        blue           = 8'h3C;
        load_sreg      = 1'b1;
        transmit_pixel = 1'b1;
        @(posedge clk) #1;
        load_sreg = 1'b0;
        watch_pixel({8'h0F, 8'hF0, 8'h3C}, 0, 0, wave_err, highs, dones, aborts, busy_cnt);
        transmit_pixel = 1'b0;
        check("combo_wave", wave_err, 0);
        check("combo_highs", highs, 156);
        check("combo_pixel_done", dones, 1);
        check("combo_busy_cycles", busy_cnt, 360);

        // DONE must fall back to IDLE once transmit is low
        repeat (2) @(negedge clk);
        check("final_busy", int'(busy), 0);
        check("final_data_out", int'(data_out), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 Parameter CYCLES_PER_BIT, default 15, is the clocks per WS2812 bit slot (800 kHz at 12 MHz).
REQ-002 Parameter T0H, default 4, is the high clocks for a 0 bit.
REQ-003 Parameter T1H, default 9, is the high clocks for a 1 bit.
REQ-004 clk  in  1  system clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 load_sreg  in  1  one-cycle strobe that captures the pixel colour.
REQ-007 transmit_pixel  in  1  level; high SHALL enable serialization of the loaded pixel.
REQ-008 red, green, blue  in  8 each  pixel colour sampled on load_sreg.
REQ-009 data_out  out  1  registered serial line to the LED chain.
REQ-010 busy  out  1  high while in SEND.
REQ-011 pixel_done  out  1  one-cycle pulse after the 24th bit slot completes.
REQ-012 abort  out  1  one-cycle pulse when a transmission is cut short.

Function
REQ-013 The block SHALL contain a 24-bit shift register sreg, a loaded flag, a bit counter (0..23) and a slot counter (0..CYCLES_PER_BIT-1).
REQ-014 States SHALL be IDLE, SEND and DONE.
REQ-015 In IDLE or DONE, load_sreg=1 SHALL set sreg <= {green, red, blue} (GRB order, MSB first) and set loaded=1.
REQ-016 In SEND, load_sreg SHALL be ignored: sreg and loaded are unchanged.
REQ-017 IDLE -> SEND SHALL occur on the edge where transmit_pixel=1 and loaded=1; on that edge, bit and slot counters SHALL be 0.
REQ-018 If load_sreg and transmit_pixel are both high in IDLE with loaded=0, the block SHALL load on that edge and enter SEND on the next edge if transmit_pixel is still high.
REQ-019 In SEND, data_out SHALL equal 1 when slot counter < (sreg[23] ? T1H : T0H), else 0; data_out is registered, so the slot counter is one cycle ahead of the value on the line.
REQ-020 Bit-slot timing SHALL be: the first data_out high cycle is the cycle after the SEND-entry edge, and each bit occupies exactly CYCLES_PER_BIT clocks.
REQ-021 When slot counter = CYCLES_PER_BIT-1, the slot counter SHALL wrap to 0, sreg SHALL shift left by one with 0 filled, and the bit counter SHALL increment.
REQ-022 When bit counter = 23 and slot counter = CYCLES_PER_BIT-1, the block SHALL go to DONE, clear loaded, and pulse pixel_done for exactly one cycle.
REQ-023 The total SEND duration SHALL be 24 x CYCLES_PER_BIT = 360 clocks at the default parameters.
REQ-024 DONE SHALL hold data_out=0 and return to IDLE when transmit_pixel=0; while transmit_pixel stays high, DONE SHALL NOT retransmit.
REQ-025 If transmit_pixel falls during SEND, on the next edge the block SHALL drive data_out=0, go to IDLE, clear loaded, and pulse abort for one cycle; pixel_done SHALL NOT pulse.
REQ-026 In IDLE and DONE, data_out SHALL be 0 and busy SHALL be 0.
REQ-027 The counters SHALL never exceed their ranges, and parameters SHALL satisfy T0H < T1H < CYCLES_PER_BIT.

Reset
REQ-028 With rst=1 on an edge, the block SHALL enter IDLE with sreg=0, loaded=0, counters=0, data_out=0, busy=0, pixel_done=0 and abort=0.
REQ-029 Reset asserted mid-SEND SHALL take priority over all other inputs, and data_out SHALL be 0 the cycle after.
REQ-030 After rst, the block SHALL require a fresh load_sreg before any transmission.

Verification
REQ-031 Load G=0xFF, R=0x00, B=0xAA, then raise transmit_pixel for 360 cycles -> 8 slots with 9 high/6 low, then 8 slots with 4 high/11 low, then alternating 9/4 high slots for 0xAA; pixel_done pulses once at cycle 360.
REQ-032 transmit_pixel high with no prior load -> data_out stays 0, busy stays 0, no pulses.
REQ-033 transmit_pixel dropped at cycle 100 of SEND -> data_out=0 next cycle, abort pulses once, busy falls; a new load plus transmit sends the full new pixel.
REQ-034 load_sreg with different colour at cycle 50 of SEND -> the waveform is unchanged from the original pixel.
REQ-035 rst at cycle 200 of SEND -> all outputs 0 next cycle, IDLE, loaded=0.
REQ-036 Two back-to-back pixels (load, 360-cycle transmit, low 2 cycles, load, transmit) -> two complete waveforms and two pixel_done pulses with no extra high cycles between them.
